// File: rtl/regbank_sb.sv
// Parametrised register bank: two combinational read ports, ALU and load write ports, and a per-register busy scoreboard.
// Optional macro REGBANK_BYPASS_EN enables read-after-write forwarding on both read ports.
module regbank_sb #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] rd1,
    output logic          rv1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd2,
    output logic          rv2,
    input  logic          w_en,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          l_en,
    input  logic [AW-1:0] la,
    input  logic [DW-1:0] ld,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_a,
    output logic          iss_rdy,
    output logic [AW:0]   busy_cnt,
    output logic          err
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;

    assign iss_rdy = !busy[iss_a];

    // Load clears first, accepted issue sets afterwards so set wins on a same-address collision.
    always_comb begin
        busy_nxt = busy;
        if (l_en) begin
            busy_nxt[la] = 1'b0;
        end
        if (iss_en && iss_rdy) begin
            busy_nxt[iss_a] = 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
            err      <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (iss_en && !iss_rdy) begin
                err <= 1'b1;
            end
        end
    end

    // Load writeback has priority over the ALU on the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (l_en && (la == AW'(i))) begin
                    regs[i] <= ld;
                end else if (w_en && (wa == AW'(i))) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        rv1 = !busy[ra1];
        rd2 = regs[ra2];
        rv2 = !busy[ra2];
`ifdef REGBANK_BYPASS_EN
        if (l_en && (la == ra1)) begin
            rd1 = ld;
            rv1 = 1'b1;
        end else if (w_en && (wa == ra1)) begin
            rd1 = wd;
        end
        if (l_en && (la == ra2)) begin
            rd2 = ld;
            rv2 = 1'b1;
        end else if (w_en && (wa == ra2)) begin
            rd2 = wd;
        end
`endif
    end

endmodule

// File: tb/tb_regbank_sb.sv
// Directed, table-driven bench for regbank_sb (default 32x16 configuration).
`timescale 1ns/1ps
module tb_regbank_sb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ra1, ra2, wa, la, iss_a;
    logic [31:0] rd1, rd2, wd, ld;
    logic        rv1, rv2, w_en, l_en, iss_en, iss_rdy, err;
    logic [4:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    regbank_sb #(.DW(32), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ra1(ra1), .rd1(rd1), .rv1(rv1),
        .ra2(ra2), .rd2(rd2), .rv2(rv2),
        .w_en(w_en), .wa(wa), .wd(wd),
        .l_en(l_en), .la(la), .ld(ld),
        .iss_en(iss_en), .iss_a(iss_a), .iss_rdy(iss_rdy),
        .busy_cnt(busy_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        w_en;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        l_en;
        logic [3:0]  la;
        logic [31:0] ld;
        logic        iss_en;
        logic [3:0]  iss_a;
        logic [31:0] e_rd1;
        logic        e_rv1;
        logic [31:0] e_rd2;
        logic        e_rv2;
        logic        e_rdy;
        logic [4:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t tab1 [8];
    vec_t tab2 [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive a vector for one edge, then drop the enables and compare post-edge state.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        @(negedge clk);
        ra1 = v.ra1; ra2 = v.ra2;
        w_en = v.w_en; wa = v.wa; wd = v.wd;
        l_en = v.l_en; la = v.la; ld = v.ld;
        iss_en = v.iss_en; iss_a = v.iss_a;
        @(posedge clk);
        #1;
        w_en = 1'b0; l_en = 1'b0; iss_en = 1'b0;
        #1;
        tag = $sformatf("vec%0d", idx);
        chk({tag, ".rd1"}, rd1, v.e_rd1);
        chk({tag, ".rv1"}, 32'(rv1), 32'(v.e_rv1));
        chk({tag, ".rd2"}, rd2, v.e_rd2);
        chk({tag, ".rv2"}, 32'(rv2), 32'(v.e_rv2));
        chk({tag, ".iss_rdy"}, 32'(iss_rdy), 32'(v.e_rdy));
        chk({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(v.e_cnt));
        chk({tag, ".err"}, 32'(err), 32'(v.e_err));
    endtask

    initial begin
        //          ra1 ra2 w  wa  wd             l  la  ld             i  ia  rd1            rv1 rd2            rv2 rdy cnt err
        tab1[0] = '{5,  3,  0, 0,  32'h0,         0, 0,  32'h0,         1, 5,  32'h0,         0,  32'h1234,      1,  0,  1,  0};
        tab1[1] = '{5,  3,  1, 5,  32'hAAAA,      0, 0,  32'h0,         0, 5,  32'hAAAA,      0,  32'h1234,      1,  0,  1,  0};
        tab1[2] = '{5,  5,  0, 0,  32'h0,         1, 5,  32'hBEEF,      0, 5,  32'hBEEF,      1,  32'hBEEF,      1,  1,  0,  0};
        tab1[3] = '{7,  7,  1, 7,  32'h1,         1, 7,  32'h2,         0, 0,  32'h2,         1,  32'h2,         1,  1,  0,  0};
        tab1[4] = '{8,  6,  1, 8,  32'h88,        1, 6,  32'h66,        0, 0,  32'h88,        1,  32'h66,        1,  1,  0,  0};
        tab1[5] = '{5,  3,  0, 0,  32'h0,         0, 0,  32'h0,         1, 5,  32'hBEEF,      0,  32'h1234,      1,  0,  1,  0};
        tab1[6] = '{5,  3,  0, 0,  32'h0,         0, 0,  32'h0,         1, 5,  32'hBEEF,      0,  32'h1234,      1,  0,  1,  1};
        tab1[7] = '{5,  5,  0, 0,  32'h0,         1, 5,  32'h55,        0, 5,  32'h55,        1,  32'h55,        1,  1,  0,  1};
        tab2[0] = '{9,  7,  0, 0,  32'h0,         0, 0,  32'h0,         1, 9,  32'h0,         0,  32'h0,         1,  0,  1,  0};
        tab2[1] = '{9,  7,  0, 0,  32'h0,         1, 9,  32'h99,        1, 9,  32'h99,        1,  32'h0,         1,  1,  0,  1};
        tab2[2] = '{9,  7,  0, 0,  32'h0,         1, 9,  32'h77,        1, 9,  32'h77,        0,  32'h0,         1,  0,  1,  1};

        rst_n = 1'b0;
        ra1 = '0; ra2 = '0; wa = '0; la = '0; iss_a = '0;
        wd = '0; ld = '0; w_en = 1'b0; l_en = 1'b0; iss_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst.busy_cnt", 32'(busy_cnt), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        for (int a = 0; a < 16; a++) begin
            ra1 = 4'(a); ra2 = 4'(15 - a);
            #1;
            chk($sformatf("rst.rd1[%0d]", a), rd1, 32'h0);
            chk($sformatf("rst.rd2[%0d]", 15 - a), rd2, 32'h0);
            chk($sformatf("rst.rv[%0d]", a), 32'({rv1, rv2}), 32'd3);
        end

        // Same-cycle read of a register being written.
        @(negedge clk);
        w_en = 1'b1; wa = 4'd3; wd = 32'h1234; ra1 = 4'd3;
        #1;
`ifdef REGBANK_BYPASS_EN
        chk("raw.same_cycle", rd1, 32'h1234);
`else
        chk("raw.same_cycle", rd1, 32'h0);
`endif
        @(posedge clk);
        #1;
        w_en = 1'b0;
        #1;
        chk("raw.next_cycle", rd1, 32'h1234);
        chk("raw.rv1", 32'(rv1), 32'd1);

        for (int i = 0; i < 8; i++) apply(tab1[i], i);

        // Fill the scoreboard completely.
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            iss_en = 1'b1; iss_a = 4'(a);
            @(posedge clk);
            #1;
            iss_en = 1'b0;
        end
        #1;
        chk("full.busy_cnt", 32'(busy_cnt), 32'd16);
        chk("full.err", 32'(err), 32'd1);
        for (int a = 0; a < 16; a++) begin
            iss_a = 4'(a);
            #1;
            chk($sformatf("full.iss_rdy[%0d]", a), 32'(iss_rdy), 32'd0);
        end
        ra1 = 4'd7;
        #1;
        chk("full.rd1_r7", rd1, 32'h2);
        chk("full.rv1_r7", 32'(rv1), 32'd0);

        // Asynchronous reset between edges takes effect immediately.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.busy_cnt", 32'(busy_cnt), 32'd0);
        chk("arst.err", 32'(err), 32'd0);
        chk("arst.rd1_r7", rd1, 32'h0);
        chk("arst.rv1_r7", 32'(rv1), 32'd1);
        chk("arst.iss_rdy", 32'(iss_rdy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) apply(tab2[i], 8 + i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regbank_sb.md
Name: regbank_sb

Overview:
- Parametrised successor to the 16x32 two-read/one-write register bank.
- Adds configurable width and depth, a second write port for load writeback, and a per-register busy scoreboard for pending loads.
- Adds asynchronous clear of all state.
- Sits between decode/issue, the ALU writeback path and the load/store unit of the OC core.

Parameters:
DW, 32, data width of each register in bits
AW, 4, address width; depth = 2**AW registers

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
ra1  input  AW  read address, port 1
rd1  output  DW  read data, port 1 (combinational)
rv1  output  1  port 1 data valid (register not busy)
ra2  input  AW  read address, port 2
rd2  output  DW  read data, port 2 (combinational)
rv2  output  1  port 2 data valid
w_en  input  1  ALU writeback enable
wa  input  AW  ALU writeback address
wd  input  DW  ALU writeback data
l_en  input  1  load writeback enable
la  input  AW  load writeback address
ld  input  DW  load writeback data
iss_en  input  1  issue of a load targeting iss_a (marks it busy)
iss_a  input  AW  load destination address
iss_rdy  output  1  high when busy[iss_a]==0 (combinational)
busy_cnt  output  AW+1  registered count of busy registers
err  output  1  sticky: issue to a busy register attempted

Behaviour:
- Reset (rst_n low, async): all registers = 0, all busy bits = 0, busy_cnt = 0, err = 0. Outputs follow immediately. A pending load in flight at reset is forgotten; a later l_en still writes data and clears the (already clear) busy bit.
- Reads: rd = r[ra], rv = !busy[ra], zero latency. The two ports are independent and may use the same address.
- Write ports, posedge:
  - w_en: r[wa] <= wd.
  - l_en: r[la] <= ld.
  - Both enabled with wa==la: the load data wins and the ALU write is dropped.
  - Different addresses: both writes happen in the same cycle.
- ALU write to a busy register: the data is stored and busy is unchanged. The later load overwrites it (WAW resolved by the load).
- Scoreboard, posedge:
  - iss_en && iss_rdy: busy[iss_a] <= 1.
  - iss_en && !iss_rdy: no state change, err <= 1 (sticky until reset).
  - l_en: busy[la] <= 0.
  - iss_en and l_en in the same cycle with iss_a==la, and the register currently busy: iss_rdy is 0, so the issue is rejected and err is set. The load clears busy.
  - iss_en and l_en in the same cycle with iss_a==la, and the register not busy: the issue sets busy. Set wins over clear.
- busy_cnt: registered popcount of the busy vector after the update. It equals the number of set bits one cycle after any change. Range 0..2**AW; all registers busy gives 2**AW (no wrap).
- Reads during a write cycle return the old value until the posedge (no forwarding unless the feature is enabled).
- Address wrap: addresses are AW bits, so there are no out-of-range accesses.

Optional Feature:
Macro REGBANK_BYPASS_EN.
- Defined: read-after-write forwarding. Per read port, priority order:
  - l_en && la==ra: rd = ld, rv = 1.
  - else w_en && wa==ra: rd = wd, rv = !busy[ra].
  - else: array value.
- Undefined: rd and rv reflect array and scoreboard state only. The new value is visible the cycle after the write.

Test Plan:
- Reset then read all 16 addresses on both ports -> rd1=rd2=0, rv1=rv2=1, busy_cnt=0, err=0.
- w_en, wa=3, wd=0x1234; next cycle ra1=3 -> rd1=0x1234, rv1=1. Same cycle as the write: rd1=0 without bypass, 0x1234 with REGBANK_BYPASS_EN.
- iss_en, iss_a=5 -> next cycle rv1=0 for ra1=5 and busy_cnt=1. Then l_en, la=5, ld=0xBEEF -> rd1=0xBEEF, rv1=1, busy_cnt=0.
- Same cycle w_en/wa=7/wd=1 and l_en/la=7/ld=2 -> r[7]=2. Issue to busy register 5 -> err=1, busy_cnt unchanged.
- Issue to all 16 registers over 16 cycles -> busy_cnt=16, iss_rdy=0 for every address. Pull rst_n low mid-sequence between clock edges -> busy_cnt=0 and all registers 0 immediately.
- Register 9 busy, then iss_en/iss_a=9 with l_en/la=9 in the same cycle -> issue rejected, err=1, busy[9]=0. Repeat with register 9 not busy -> busy[9]=1.
